// File: rtl/ysyx_25020037_lsu_resp.sv
// Load/store stage: accepts ops from execute, performs AXI4-Lite-style data
// accesses, aligns/extends load data and presents a registered result to write-back.
module ysyx_25020037_lsu_resp #(
    parameter int unsigned PASS_WD = 64,
    parameter int unsigned ADDR_WD = 32
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               exu_valid,
    output logic               lsu_ready,
    input  logic               in_is_load,
    input  logic               in_is_store,
    input  logic [1:0]         in_size,
    input  logic               in_unsigned,
    input  logic [ADDR_WD-1:0] in_addr,
    input  logic [31:0]        in_wdata,
    input  logic [PASS_WD-1:0] in_pass,
    output logic [31:0]        rdata_processed,

    output logic               lsu_valid,
    input  logic               wbu_ready,
    output logic [31:0]        out_result,
    output logic [PASS_WD-1:0] out_pass,
    output logic               lsu_err,

    output logic [ADDR_WD-1:0] araddr,
    output logic               arvalid,
    input  logic               arready,
    input  logic [31:0]        rdata,
    input  logic [1:0]         rresp,
    input  logic               rvalid,
    output logic               rready,

    output logic [ADDR_WD-1:0] awaddr,
    output logic               awvalid,
    input  logic               awready,
    output logic [31:0]        wdata,
    output logic [3:0]         wstrb,
    output logic               wvalid,
    input  logic               wready,
    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WREQ  = 3'd3,
        WRESP = 3'd4,
        HOLD  = 3'd5
    } state_t;

    state_t      state;
    logic [1:0]  addr_q;
    logic [1:0]  size_q;
    logic        uns_q;

    logic        accept;
    logic        misaligned;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;
    logic        aw_done;
    logic        w_done;

    assign lsu_ready = (state == IDLE) && (!lsu_valid || wbu_ready);
    assign accept    = exu_valid && lsu_ready;

    // Size 3 is treated as a word access throughout.
    assign misaligned = ((in_size == 2'd1) && in_addr[0]) ||
                        (in_size[1] && (in_addr[1:0] != 2'b00));

    always_comb begin
        st_strb = 4'b1111;
        st_data = in_wdata;
        case (in_size)
            2'd0: begin
                st_strb = 4'(4'b0001 << in_addr[1:0]);
                st_data = {4{in_wdata[7:0]}};
            end
            2'd1: begin
                st_strb = 4'(4'b0011 << {in_addr[1], 1'b0});
                st_data = {2{in_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane select uses the original address so misaligned halves still pick a lane.
    always_comb begin
        ld_byte  = rdata[{addr_q, 3'b000} +: 8];
        ld_half  = rdata[{addr_q[1], 4'b0000} +: 16];
        load_val = rdata;
        case (size_q)
            2'd0: load_val = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'd1: load_val = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

    assign aw_done = !awvalid || awready;
    assign w_done  = !wvalid || wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            addr_q          <= 2'b00;
            size_q          <= 2'b00;
            uns_q           <= 1'b0;
            lsu_valid       <= 1'b0;
            lsu_err         <= 1'b0;
            out_result      <= 32'b0;
            out_pass        <= '0;
            rdata_processed <= 32'b0;
            araddr          <= '0;
            arvalid         <= 1'b0;
            rready          <= 1'b0;
            awaddr          <= '0;
            awvalid         <= 1'b0;
            wdata           <= 32'b0;
            wstrb           <= 4'b0;
            wvalid          <= 1'b0;
            bready          <= 1'b0;
        end else begin
            lsu_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q    <= in_addr[1:0];
                        size_q    <= in_size;
                        uns_q     <= in_unsigned;
                        out_pass  <= in_pass;
                        lsu_valid <= 1'b0;
                        if (in_is_load) begin
                            lsu_err <= misaligned;
                            araddr  <= {in_addr[ADDR_WD-1:2], 2'b00};
                            arvalid <= 1'b1;
                            state   <= RADDR;
                        end else if (in_is_store) begin
                            lsu_err <= misaligned;
                            awaddr  <= {in_addr[ADDR_WD-1:2], 2'b00};
                            wdata   <= st_data;
                            wstrb   <= st_strb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WREQ;
                        end else begin
                            lsu_valid  <= 1'b1;
                            out_result <= 32'(in_addr);
                        end
                    end else if (lsu_valid) begin
                        if (wbu_ready) begin
                            lsu_valid <= 1'b0;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                RADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RDATA;
                    end
                end
                RDATA: begin
                    if (rvalid) begin
                        rready          <= 1'b0;
                        rdata_processed <= load_val;
                        out_result      <= load_val;
                        lsu_valid       <= 1'b1;
                        lsu_err         <= (rresp != 2'b00);
                        state           <= IDLE;
                    end
                end
                WREQ: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready <= 1'b1;
                        state  <= WRESP;
                    end
                end
                WRESP: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        out_result <= 32'b0;
                        lsu_valid  <= 1'b1;
                        lsu_err    <= (bresp != 2'b00);
                        state      <= IDLE;
                    end
                end
                HOLD: begin
                    if (wbu_ready) begin
                        lsu_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_lsu_resp.sv
// Directed bench for the LSU: non-memory pass-through, loads, stores,
// write-back backpressure and reset during an outstanding read.
module tb_ysyx_25020037_lsu_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, lsu_ready, in_is_load, in_is_store, in_unsigned;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata, rdata_processed;
    logic [63:0] in_pass, out_pass;
    logic        lsu_valid, wbu_ready, lsu_err;
    logic [31:0] out_result;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_25020037_lsu_resp #(.PASS_WD(64), .ADDR_WD(32)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .lsu_ready(lsu_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_size(in_size), .in_unsigned(in_unsigned),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_pass(in_pass),
        .rdata_processed(rdata_processed),
        .lsu_valid(lsu_valid), .wbu_ready(wbu_ready),
        .out_result(out_result), .out_pass(out_pass), .lsu_err(lsu_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single accepting cycle.
    task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        exu_valid   = 1'b1;
        in_is_load  = ld;
        in_is_store = st;
        in_size     = sz;
        in_unsigned = uns;
        in_addr     = a;
        in_wdata    = wd;
        chk("issue_ready", 64'(lsu_ready), 64'd1);
        step();
        exu_valid   = 1'b0;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!lsu_valid && n < 20) begin
            step();
            n++;
        end
        chk(tag, 64'(lsu_valid), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        exu_valid = 0; in_is_load = 0; in_is_store = 0; in_size = 0; in_unsigned = 0;
        in_addr = 0; in_wdata = 0; in_pass = 64'hCAFE_F00D_1234_5678;
        wbu_ready = 1; arready = 0; rdata = 0; rresp = 0; rvalid = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
        step(); step();
        rst = 1'b0;
        chk("rst_valids", {58'b0, lsu_valid, arvalid, awvalid, wvalid, rready, bready}, 64'd0);
        chk("rst_result", 64'(out_result), 64'd0);
        chk("rst_rdp", 64'(rdata_processed), 64'd0);
        chk("rst_ready", 64'(lsu_ready), 64'd1);

        // Non-memory ops back to back
        issue(0, 0, 2'd2, 0, 32'h0000_1234, 0);
        chk("nm1_valid", 64'(lsu_valid), 64'd1);
        chk("nm1_result", 64'(out_result), 64'h1234);
        chk("nm1_pass", out_pass, 64'hCAFE_F00D_1234_5678);
        issue(0, 0, 2'd2, 0, 32'h0000_5678, 0);
        chk("nm2_valid", 64'(lsu_valid), 64'd1);
        chk("nm2_result", 64'(out_result), 64'h5678);
        step();
        chk("nm_drain", 64'(lsu_valid), 64'd0);

        // LB signed at byte lane 3, immediate handshakes
        arready = 1; rvalid = 1; rdata = 32'h80AA_BBCC;
        issue(1, 0, 2'd0, 0, 32'h8000_0003, 0);
        chk("lb_araddr", 64'(araddr), 64'h8000_0000);
        chk("lb_arvalid", 64'(arvalid), 64'd1);
        chk("lb_busy1", 64'(lsu_ready), 64'd0);
        step();
        chk("lb_rready", 64'(rready), 64'd1);
        chk("lb_busy2", 64'(lsu_ready), 64'd0);
        step();
        chk("lb_valid", 64'(lsu_valid), 64'd1);
        chk("lb_result", 64'(out_result), 64'hFFFF_FF80);
        chk("lb_rdp", 64'(rdata_processed), 64'hFFFF_FF80);
        chk("lb_err", 64'(lsu_err), 64'd0);

        // LHU upper half, then a non-load must not disturb rdata_processed
        rdata = 32'hBEEF_0000;
        issue(1, 0, 2'd1, 1, 32'h8000_0002, 0);
        wait_valid("lhu_valid");
        chk("lhu_result", 64'(out_result), 64'h0000_BEEF);
        issue(0, 0, 2'd2, 0, 32'h0000_0099, 0);
        chk("nm3_result", 64'(out_result), 64'h99);
        chk("nm3_rdp", 64'(rdata_processed), 64'h0000_BEEF);

        // Misaligned LH: error pulse right after accept, signed lower half
        rdata = 32'h0000_ABCD;
        issue(1, 0, 2'd1, 0, 32'h4000_0001, 0);
        chk("lhm_err", 64'(lsu_err), 64'd1);
        chk("lhm_araddr", 64'(araddr), 64'h4000_0000);
        wait_valid("lhm_valid");
        chk("lhm_result", 64'(out_result), 64'hFFFF_ABCD);
        chk("lhm_err_clr", 64'(lsu_err), 64'd0);

        // LW with error response: data used, error pulses at completion
        rdata = 32'hCAFE_BABE; rresp = 2'd2;
        issue(1, 0, 2'd2, 0, 32'h5000_0008, 0);
        wait_valid("lwe_valid");
        chk("lwe_result", 64'(out_result), 64'hCAFE_BABE);
        chk("lwe_err", 64'(lsu_err), 64'd1);
        rresp = 2'd0;

        // SB with AW accepted two cycles ahead of W
        awready = 0; wready = 0;
        issue(0, 1, 2'd0, 0, 32'h1000_0001, 32'h1234_565A);
        chk("sb_vld", {62'b0, awvalid, wvalid}, 64'd3);
        chk("sb_awaddr", 64'(awaddr), 64'h1000_0000);
        chk("sb_wstrb", 64'(wstrb), 64'b0010);
        chk("sb_wdata", 64'(wdata), 64'h5A5A_5A5A);
        awready = 1;
        step();
        awready = 0;
        chk("sb_aw_hs", {61'b0, awvalid, wvalid, bready}, 64'b010);
        step();
        chk("sb_wait", {61'b0, awvalid, wvalid, bready}, 64'b010);
        wready = 1;
        step();
        wready = 0;
        chk("sb_w_hs", {61'b0, awvalid, wvalid, bready}, 64'b001);
        bvalid = 1;
        step();
        bvalid = 0;
        chk("sb_valid", 64'(lsu_valid), 64'd1);
        chk("sb_result", 64'(out_result), 64'd0);
        chk("sb_bready", 64'(bready), 64'd0);

        // Load completes under write-back backpressure
        arready = 1; rvalid = 1; rdata = 32'h1122_3344;
        issue(1, 0, 2'd2, 0, 32'h2000_0000, 0);
        wbu_ready = 0;
        wait_valid("hold_valid");
        exu_valid = 1; in_addr = 32'h77;
        for (int i = 0; i < 3; i++) begin
            chk("hold_lsu_valid", 64'(lsu_valid), 64'd1);
            chk("hold_result", 64'(out_result), 64'h1122_3344);
            chk("hold_ready", 64'(lsu_ready), 64'd0);
            step();
        end
        wbu_ready = 1;
        begin
            int n = 0;
            while (!(lsu_valid && out_result == 32'h77) && n < 10) begin
                step();
                n++;
            end
        end
        exu_valid = 0;
        chk("hold_release", 64'(out_result), 64'h77);

        // Reset while waiting for read data; late response is ignored
        rvalid = 0;
        issue(1, 0, 2'd2, 0, 32'h3000_0000, 0);
        step();
        chk("rr_rready", 64'(rready), 64'd1);
        rst = 1;
        step();
        rst = 0;
        chk("rr_valids", {58'b0, lsu_valid, arvalid, awvalid, wvalid, rready, bready}, 64'd0);
        chk("rr_ready", 64'(lsu_ready), 64'd1);
        rvalid = 1; rdata = 32'hDEAD_BEEF;
        step(); step();
        chk("rr_ignored", {63'b0, lsu_valid}, 64'd0);
        chk("rr_rdp", 64'(rdata_processed), 64'd0);
        chk("rr_idle", {62'b0, arvalid, rready}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_25020037_lsu_resp.md
Name: ysyx_25020037_lsu_resp

Overview:
- Load/store stage sitting directly downstream of the execute stage in the 5-stage core.
- Responder end of the execute→LSU handshake: accepts `exu_valid` plus decoded memory fields, returns `lsu_ready` and `rdata_processed`.
- Performs the data access over an AXI4-Lite-style master port, aligns/extends load data, and hands a registered result to write-back.
- Holds `lsu_ready` low while any memory access is outstanding, so execute stalls load-dependent instructions.

Parameters:
- PASS_WD, 64, width of the opaque write-back/CSR sideband copied from input to output unchanged.
- ADDR_WD, 32, address width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- exu_valid  input  1  execute presents an instruction this cycle
- lsu_ready  output  1  LSU accepts this cycle
- in_is_load  input  1  instruction is a load
- in_is_store  input  1  instruction is a store
- in_size  input  2  0=byte 1=half 2=word
- in_unsigned  input  1  zero-extend load
- in_addr  input  32  ALU result: effective address, or rd value for non-memory ops
- in_wdata  input  32  store data (rs2)
- in_pass  input  PASS_WD  sideband to write-back
- rdata_processed  output  32  last completed load value, aligned and extended
- lsu_valid  output  1  result valid to write-back
- wbu_ready  input  1  write-back accepts
- out_result  output  32  load data or passed-through `in_addr`
- out_pass  output  PASS_WD  registered `in_pass`
- lsu_err  output  1  one-cycle pulse: misaligned access or nonzero resp
- araddr  output  32;  arvalid  output  1;  arready  input  1
- rdata  input  32;  rresp  input  2;  rvalid  input  1;  rready  output  1
- awaddr  output  32;  awvalid  output  1;  awready  input  1
- wdata  output  32;  wstrb  output  4;  wvalid  output  1;  wready  input  1
- bresp  input  2;  bvalid  input  1;  bready  output  1

Behaviour:
- States: IDLE, RADDR, RDATA, WREQ, WRESP, HOLD.
- Reset (synchronous): state=IDLE; `lsu_valid`, `arvalid`, `awvalid`, `wvalid`, `rready`, `bready`, `lsu_err` = 0; `rdata_processed`, `out_result`, `out_pass` = 0. Reset mid-transaction abandons the access; no outputs reassert until a new accept.
- `lsu_ready` = (state==IDLE) && (!`lsu_valid` || `wbu_ready`). Combinational; depends on no input other than `wbu_ready`.
- Accept = `exu_valid` && `lsu_ready`. On accept, latch all `in_*` fields, and clear `lsu_valid` if `wbu_ready`.
- Non-memory accept: next cycle `lsu_valid`=1, `out_result`=`in_addr`. Latency 1; back-to-back throughput 1/cycle.
- Load accept → RADDR: `arvalid`=1, `araddr`={addr[31:2],2'b00}.
  - On `arready`: go to RDATA, `rready`=1.
  - On `rvalid`: byte lane = addr[1:0]; half lane = addr[1]; sign/zero-extend per `in_unsigned`. Register the value into both `rdata_processed` and `out_result`; `lsu_valid`=1; state=IDLE.
  - Load latency ≥ 3 cycles from accept to `lsu_valid`.
- `rdata_processed` changes only on load completion and holds otherwise. Execute samples it one cycle after any cycle with `lsu_ready`=1.
- Store accept → WREQ: assert `awvalid` and `wvalid` in the same cycle.
  - `awaddr` word-aligned; `wdata` = store data replicated into lanes (byte ×4, half ×2).
  - `wstrb`: byte = 0001<<addr[1:0]; half = 0011<<{addr[1],0}; word = 1111.
  - Each valid drops independently on its own handshake; handshakes may occur in either order or together.
  - When both are done: WRESP, `bready`=1. On `bvalid`: `lsu_valid`=1 with `out_result`=0, state=IDLE.
- HOLD: entered from any completion while `lsu_valid`=1 and `wbu_ready`=0. Outputs are held stable; `lsu_ready`=0 until `wbu_ready`.
- Misalignment (half with addr[0]=1, word with addr[1:0]≠0): access still issued with the address forced down to alignment; `lsu_err` pulses on the accept+1 cycle.
- Nonzero `rresp`/`bresp`: data is still used; `lsu_err` pulses in the completion cycle.
- `in_is_load` and `in_is_store` both set is illegal; treat as load.

Test Plan:
- Non-memory op, `in_addr`=0x1234, `wbu_ready`=1 → `lsu_valid` next cycle with `out_result`=0x1234; a second op the following cycle is also accepted (throughput 1).
- LB at addr 0x8000_0003, `rdata`=0x80AA_BBCC, `arready`/`rvalid` immediate → `araddr`=0x8000_0000, `out_result`=`rdata_processed`=0xFFFF_FF80; `lsu_ready` low from accept until completion.
- LHU at 0x...02, `rdata`=0xBEEF_0000 → 0x0000_BEEF; then a non-load → `rdata_processed` stays 0x0000_BEEF.
- SB at 0x...01 of data 0x5A, `awready` two cycles before `wready` → `wstrb`=0010, `wdata`=0x5A5A_5A5A; `bready` asserts only after both handshakes.
- Load completes with `wbu_ready`=0 for 3 cycles → `lsu_valid` and `out_result` stable, `lsu_ready`=0; an incoming `exu_valid` is not accepted until `wbu_ready` rises.
- Reset asserted while in RDATA → next cycle all valids 0, state IDLE; a later response with `rvalid`=1 is ignored.
